// File: rtl/fpdiv_ctrl.sv
// fpdiv_ctrl: start/done sequencer for the Goldschmidt divider datapath.
// Rev 1.0 - initial release.
`default_nettype none

module fpdiv_ctrl #(
  parameter int ITER_SP = 6,
  parameter int ITER_DP = 8,
  parameter int CW      = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          prec,
  input  logic          special,
  input  logic          ack,
  output logic          busy,
  output logic          done,
  output logic [1:0]    sel_mux4,
  output logic [1:0]    sel_mux3,
  output logic          en_a,
  output logic          en_b,
  output logic          en_rem,
  output logic          en_res,
  output logic          bypass,
  output logic [CW-1:0] iter
);

  if (ITER_SP < 1 || ITER_SP >= (1 << CW)) begin : g_bad_iter_sp
    $error("ITER_SP must be in 1..2**CW-1");
  end
  if (ITER_DP < 1 || ITER_DP >= (1 << CW)) begin : g_bad_iter_dp
    $error("ITER_DP must be in 1..2**CW-1");
  end

  localparam logic [CW-1:0] LIM_SP = CW'(ITER_SP);
  localparam logic [CW-1:0] LIM_DP = CW'(ITER_DP);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_N0   = 3'd1,
    S_D0   = 3'd2,
    S_NI   = 3'd3,
    S_DI   = 3'd4,
    S_REM  = 3'd5,
    S_RND  = 3'd6,
    S_DONE = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] iter_q, iter_d;
  logic [CW-1:0] limit_q, limit_d;
  logic          bypass_q, bypass_d;
  logic          accept;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      iter_q   <= '0;
      limit_q  <= '0;
      bypass_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      limit_q  <= limit_d;
      bypass_q <= bypass_d;
    end
  end

  // A new operation may start from IDLE, or from DONE once the result is acked.
  assign accept = start & ((state_q == S_IDLE) | ((state_q == S_DONE) & ack));

  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    limit_d  = limit_q;
    bypass_d = bypass_q;
    if (accept) begin
      limit_d  = prec ? LIM_DP : LIM_SP;
      bypass_d = special;
      if (special) begin
        state_d = S_DONE;
        iter_d  = '0;
      end else begin
        state_d = S_N0;
        iter_d  = ONE;
      end
    end else begin
      case (state_q)
        S_N0:  state_d = S_D0;
        S_D0: begin
          if (limit_q > ONE) begin
            state_d = S_NI;
            iter_d  = iter_q + ONE;
          end else begin
            state_d = S_REM;
            iter_d  = '0;
          end
        end
        S_NI:  state_d = S_DI;
        S_DI: begin
          if (iter_q == limit_q) begin
            state_d = S_REM;
            iter_d  = '0;
          end else begin
            state_d = S_NI;
            iter_d  = iter_q + ONE;
          end
        end
        S_REM: state_d = S_RND;
        S_RND: state_d = S_DONE;
        S_DONE: begin
          if (ack) begin
            state_d  = S_IDLE;
            bypass_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decode from registered state only.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    sel_mux4 = 2'b00;
    sel_mux3 = 2'b00;
    en_a     = 1'b0;
    en_b     = 1'b0;
    en_rem   = 1'b0;
    en_res   = 1'b0;
    bypass   = bypass_q;
    iter     = iter_q;
    case (state_q)
      S_N0: begin
        busy = 1'b1;
        en_a = 1'b1;
      end
      S_D0: begin
        busy     = 1'b1;
        sel_mux4 = 2'b01;
        en_b     = 1'b1;
      end
      S_NI: begin
        busy     = 1'b1;
        sel_mux4 = 2'b10;
        sel_mux3 = 2'b01;
        en_a     = 1'b1;
      end
      S_DI: begin
        busy     = 1'b1;
        sel_mux4 = 2'b11;
        sel_mux3 = 2'b01;
        en_b     = 1'b1;
      end
      S_REM: begin
        busy     = 1'b1;
        sel_mux4 = 2'b10;
        sel_mux3 = 2'b10;
        en_rem   = 1'b1;
      end
      S_RND: begin
        busy   = 1'b1;
        en_res = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_fpdiv_ctrl.sv
// tb_fpdiv_ctrl: directed self-checking bench for fpdiv_ctrl with a cycle-level reference model.
// Rev 1.0 - initial release.
`default_nettype none

module tb_fpdiv_ctrl;

  localparam int ITER_SP = 6;
  localparam int ITER_DP = 8;
  localparam int CW      = 4;

  logic          clk = 1'b0;
  logic          reset, start, prec, special, ack;
  logic          busy, done, en_a, en_b, en_rem, en_res, bypass;
  logic [1:0]    sel_mux4, sel_mux3;
  logic [CW-1:0] iter;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  fpdiv_ctrl #(.ITER_SP(ITER_SP), .ITER_DP(ITER_DP), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .prec(prec), .special(special), .ack(ack),
    .busy(busy), .done(done), .sel_mux4(sel_mux4), .sel_mux3(sel_mux3),
    .en_a(en_a), .en_b(en_b), .en_rem(en_rem), .en_res(en_res),
    .bypass(bypass), .iter(iter)
  );

  logic [14:0] dut_vec;
  assign dut_vec = {busy, done, sel_mux4, sel_mux3, en_a, en_b, en_rem, en_res, bypass, iter};

  // Reference model: m_idx is the cycle position inside a divide (0..2L+1), -1 when not busy.
  int m_idx = -1;
  int m_lim = ITER_SP;
  bit m_done = 1'b0;
  bit m_byp  = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_idx  <= -1;
      m_done <= 1'b0;
      m_byp  <= 1'b0;
    end else if (m_idx >= 0) begin
      if (m_idx == 2 * m_lim + 1) begin
        m_idx  <= -1;
        m_done <= 1'b1;
      end else begin
        m_idx <= m_idx + 1;
      end
    end else if (start && (!m_done || ack)) begin
      m_lim  <= prec ? ITER_DP : ITER_SP;
      m_byp  <= special;
      m_done <= special;
      m_idx  <= special ? -1 : 0;
    end else if (m_done && ack) begin
      m_done <= 1'b0;
      m_byp  <= 1'b0;
    end
  end

  function automatic logic [14:0] exp_vec();
    logic       b, ea, eb, er, es;
    logic [1:0] s4, s3;
    int         it;
    b = (m_idx >= 0);
    ea = 0; eb = 0; er = 0; es = 0; s4 = 0; s3 = 0; it = 0;
    if (b) begin
      if (m_idx < 2 * m_lim) begin
        ea = (m_idx % 2 == 0);
        eb = (m_idx % 2 == 1);
        s4 = (m_idx == 0) ? 2'd0 : (m_idx == 1) ? 2'd1 : (m_idx % 2 == 0) ? 2'd2 : 2'd3;
        s3 = (m_idx < 2) ? 2'd0 : 2'd1;
        it = m_idx / 2 + 1;
      end else if (m_idx == 2 * m_lim) begin
        er = 1; s4 = 2'd2; s3 = 2'd2;
      end else begin
        es = 1;
      end
    end
    return {b, m_done, s4, s3, ea, eb, er, es, m_done & m_byp, it[CW-1:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) chk("cycle_outputs", {17'd0, dut_vec}, {17'd0, exp_vec()});
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Observe until done (bounded), counting activity; optionally poke start while busy.
  task automatic run_wait(input bit poke, output int cyc, output int nbusy, output int na,
                          output int nb, output int nr, output int nres, output int mx,
                          output bit to);
    cyc = 0; nbusy = 0; na = 0; nb = 0; nr = 0; nres = 0; mx = 0; to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (busy)   nbusy++;
      if (en_a)   na++;
      if (en_b)   nb++;
      if (en_rem) nr++;
      if (en_res) nres++;
      if (int'(iter) > mx) mx = int'(iter);
      if (done) begin
        to = 1'b0;
        break;
      end
      if (poke) begin
        start   = (cyc >= 3 && cyc <= 6);
        special = 1'b1;
        prec    = 1'b0;
      end
    end
    start   = 1'b0;
    special = 1'b0;
  endtask

  task automatic check_run(input string tag, input bit poke, input int ecyc, input int ebusy,
                           input int epairs, input int emax);
    int cyc, nbusy, na, nb, nr, nres, mx;
    bit to;
    run_wait(poke, cyc, nbusy, na, nb, nr, nres, mx, to);
    chk({tag, "_timeout"}, {31'd0, to}, 32'd0);
    chk({tag, "_done_cycle"}, cyc, ecyc);
    chk({tag, "_busy_cycles"}, nbusy, ebusy);
    chk({tag, "_en_a_pulses"}, na, epairs);
    chk({tag, "_en_b_pulses"}, nb, epairs);
    chk({tag, "_en_rem_pulses"}, nr, (epairs == 0) ? 0 : 1);
    chk({tag, "_en_res_pulses"}, nres, (epairs == 0) ? 0 : 1);
    chk({tag, "_max_iter"}, mx, emax);
  endtask

  task automatic launch(input bit p, input bit s);
    prec = p; special = s; start = 1'b1;
    step();
    start = 1'b0; special = 1'b0;
  endtask

  task automatic ack_it();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  initial begin
    int  nd;
    bit  found;
    reset = 1'b0; start = 1'b0; prec = 1'b0; special = 1'b0; ack = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_outputs", {17'd0, dut_vec}, 32'd0);
    end

    // Single precision: 14 busy cycles, done on cycle 15.
    launch(1'b0, 1'b0);
    check_run("sp", 1'b0, 15, 14, 6, 6);
    ack_it();

    // Double precision with ignored start pulses while busy.
    launch(1'b1, 1'b0);
    check_run("dp", 1'b1, 19, 18, 8, 8);
    ack_it();

    // Special operands: immediate done with bypass, held while ack low.
    launch(1'b0, 1'b1);
    check_run("byp", 1'b0, 1, 0, 0, 0);
    repeat (4) @(negedge clk);
    chk("byp_hold", {30'd0, done, bypass}, 32'd3);
    ack_it();
    @(negedge clk);
    chk("byp_release", {29'd0, done, bypass, busy}, 32'd0);

    // Back-to-back: ack and start together in DONE.
    launch(1'b0, 1'b0);
    check_run("b2b_first", 1'b0, 15, 14, 6, 6);
    ack = 1'b1; start = 1'b1; prec = 1'b0; special = 1'b0;
    step();
    ack = 1'b0; start = 1'b0;
    check_run("b2b_second", 1'b0, 15, 14, 6, 6);
    ack_it();

    // Reset asserted in DI at iter 3 abandons the divide.
    launch(1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (en_b && iter == 4'd3) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_di_iter3", {31'd0, found}, 32'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_outputs", {17'd0, dut_vec}, 32'd0);
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("midreset_no_done", nd, 0);
    launch(1'b0, 1'b0);
    check_run("after_reset", 1'b0, 15, 14, 6, 6);
    ack_it();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
